// File: rtl/keypad_matrix_scanner.sv
// -----------------------------------------------------------------------------
// keypad_matrix_scanner
//
// Scans a 4x4 active-low matrix keypad one column at a time, debounces both
// press and release, and reports the accepted key as a 4-bit code
// {row_idx, col_idx}. The IsPressed / keyboard_data pair feeds the LED and LCD
// display blocks.
//
// Ports:
//   clk           in   system clock
//   sys_rst_n     in   asynchronous active-low reset
//   row[3:0]      in   keypad rows (pulled up, low = key closed in driven column)
//   col[3:0]      out  column drive, active-low one-cold
//   IsPressed     out  high while a debounced key is held
//   keyboard_data out  code of the last accepted key, {row_idx, col_idx}
//   key_valid     out  one-cycle pulse on key acceptance
//                      (present only when KEYPAD_PRESS_PULSE_EN is defined)
//
// Optional feature macro: KEYPAD_PRESS_PULSE_EN
// -----------------------------------------------------------------------------
module keypad_matrix_scanner #(
    parameter int SCAN_DIV       = 27000,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic       clk,
    input  logic       sys_rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       IsPressed,
    output logic [3:0] keyboard_data
`ifdef KEYPAD_PRESS_PULSE_EN
    ,
    output logic       key_valid
`endif
);

    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_TICKS - 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HOLD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_e;

    // Active-low one-cold column drive for a column index.
    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        col_drive = ~(4'b0001 << idx);
    endfunction

    // Index of the lowest-numbered low row; only called when some row is low.
    function automatic logic [1:0] lowest_low(input logic [3:0] r);
        if (!r[0]) begin
            lowest_low = 2'd0;
        end else if (!r[1]) begin
            lowest_low = 2'd1;
        end else if (!r[2]) begin
            lowest_low = 2'd2;
        end else begin
            lowest_low = 2'd3;
        end
    endfunction

    logic [3:0]    row_meta_q;
    logic [3:0]    row_sync_q;
    logic [TW-1:0] tick_cnt_q;
    logic [TW-1:0] tick_cnt_d;
    logic          tick_s;
    logic          row_low_s;
    state_e        state_q;
    logic [1:0]    col_idx_q;
    logic [1:0]    row_idx_q;
    logic [DW-1:0] deb_cnt_q;
    logic [3:0]    col_q;
    logic          pressed_q;
    logic [3:0]    kdata_q;
`ifdef KEYPAD_PRESS_PULSE_EN
    logic          key_valid_q;
`endif

    // Scan tick generation and captured-row status.
    always_comb begin
        tick_s    = (tick_cnt_q == TICK_LAST);
        row_low_s = ~row_sync_q[row_idx_q];
        if (tick_s) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
        end
    end

    // Two-flop row synchronizer and free-running tick counter.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            row_meta_q <= 4'b1111;
            row_sync_q <= 4'b1111;
            tick_cnt_q <= '0;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // Scan / debounce / hold / release state machine with registered outputs.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_SCAN;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            deb_cnt_q   <= '0;
            col_q       <= 4'b1110;
            pressed_q   <= 1'b0;
            kdata_q     <= 4'h0;
`ifdef KEYPAD_PRESS_PULSE_EN
            key_valid_q <= 1'b0;
`endif
        end else begin
`ifdef KEYPAD_PRESS_PULSE_EN
            key_valid_q <= 1'b0;
`endif
            if (tick_s) begin
                case (state_q)
                    ST_SCAN: begin
                        if (row_sync_q == 4'hF) begin
                            col_idx_q <= col_idx_q + 2'd1;
                            col_q     <= col_drive(col_idx_q + 2'd1);
                        end else begin
                            // Column stays frozen so the same key keeps being sampled.
                            row_idx_q <= lowest_low(row_sync_q);
                            deb_cnt_q <= '0;
                            state_q   <= ST_DEBOUNCE;
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (row_low_s) begin
                            if (deb_cnt_q == DEB_LAST) begin
                                kdata_q     <= {row_idx_q, col_idx_q};
                                pressed_q   <= 1'b1;
`ifdef KEYPAD_PRESS_PULSE_EN
                                key_valid_q <= 1'b1;
`endif
                                state_q     <= ST_HOLD;
                            end else begin
                                deb_cnt_q <= deb_cnt_q + DW'(1);
                            end
                        end else begin
                            // Glitch: drop it and move on to the next column.
                            col_idx_q <= col_idx_q + 2'd1;
                            col_q     <= col_drive(col_idx_q + 2'd1);
                            state_q   <= ST_SCAN;
                        end
                    end
                    ST_HOLD: begin
                        if (!row_low_s) begin
                            deb_cnt_q <= '0;
                            state_q   <= ST_RELEASE;
                        end else begin
                            state_q <= ST_HOLD;
                        end
                    end
                    ST_RELEASE: begin
                        if (!row_low_s) begin
                            if (deb_cnt_q == DEB_LAST) begin
                                pressed_q <= 1'b0;
                                col_idx_q <= col_idx_q + 2'd1;
                                col_q     <= col_drive(col_idx_q + 2'd1);
                                state_q   <= ST_SCAN;
                            end else begin
                                deb_cnt_q <= deb_cnt_q + DW'(1);
                            end
                        end else begin
                            // Release bounce: key still considered held.
                            state_q <= ST_HOLD;
                        end
                    end
                    default: begin
                        state_q <= ST_SCAN;
                    end
                endcase
            end
        end
    end

    assign col           = col_q;
    assign IsPressed     = pressed_q;
    assign keyboard_data = kdata_q;
`ifdef KEYPAD_PRESS_PULSE_EN
    assign key_valid     = key_valid_q;
`endif

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_matrix_scanner
//
// Directed bench for keypad_matrix_scanner with SCAN_DIV=4, DEBOUNCE_TICKS=3.
// A behavioural keypad pulls a row low when a closed key sits in the driven
// column. Stimulus changes just after a tick edge; one tick = 4 clocks.
// -----------------------------------------------------------------------------
module tb_keypad_matrix_scanner;

    logic        clk = 1'b0;
    logic        sys_rst_n;
    logic [15:0] keys;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        is_pressed;
    logic [3:0]  kdata;
    int          vecs = 0;
    int          errs = 0;
    logic [3:0]  col_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    always #5 clk = ~clk;

    // Keypad model: key index is row*4+col.
    function automatic logic [3:0] keypad(input logic [15:0] k, input logic [3:0] c);
        logic [3:0] r;
        r = 4'hF;
        for (int ri = 0; ri < 4; ri++) begin
            for (int ci = 0; ci < 4; ci++) begin
                if (k[ri*4+ci] && !c[ci]) begin
                    r[ri] = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign row = keypad(keys, col);

`ifdef KEYPAD_PRESS_PULSE_EN
    logic key_valid;
    int   kv_high = 0;
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            kv_high <= kv_high + 1;
        end
    end
`endif

    keypad_matrix_scanner #(
        .SCAN_DIV      (4),
        .DEBOUNCE_TICKS(3)
    ) dut (
        .clk          (clk),
        .sys_rst_n    (sys_rst_n),
        .row          (row),
        .col          (col),
        .IsPressed    (is_pressed),
        .keyboard_data(kdata)
`ifdef KEYPAD_PRESS_PULSE_EN
        ,
        .key_valid    (key_valid)
`endif
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (4 * n) @(posedge clk);
        #1;
    endtask

    initial begin
        sys_rst_n = 1'b0;
        keys      = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_col", col, 4'b1110);
        chk("rst_pressed", {3'b000, is_pressed}, 4'd0);
        chk("rst_data", kdata, 4'h0);
        @(negedge clk) sys_rst_n = 1'b1;

        // Idle scanning, ticks 1..20
        for (int t = 1; t <= 20; t++) begin
            tick(1);
            chk("idle_col", col, col_seq[t % 4]);
        end
        chk("idle_pressed", {3'b000, is_pressed}, 4'd0);
        chk("idle_data", kdata, 4'h0);

        // Key row 2 / col 1
        keys[9] = 1'b1;
        tick(1);                                            // 21
        chk("k9_col_t21", col, 4'b1101);
        tick(1);                                            // 22 detect
        chk("k9_col_t22", col, 4'b1101);
        tick(2);                                            // 24
        chk("k9_pressed_t24", {3'b000, is_pressed}, 4'd0);
        tick(1);                                            // 25 accept
        chk("k9_pressed_t25", {3'b000, is_pressed}, 4'd1);
        chk("k9_data", kdata, 4'h9);
`ifdef KEYPAD_PRESS_PULSE_EN
        chk("k9_kv", {3'b000, key_valid}, 4'd1);
`endif
        tick(5);                                            // 30
        chk("k9_hold_pressed", {3'b000, is_pressed}, 4'd1);
        chk("k9_hold_col", col, 4'b1101);
        keys = 16'h0000;
        tick(3);                                            // 33
        chk("k9_rel_t33", {3'b000, is_pressed}, 4'd1);
        tick(1);                                            // 34 release accepted
        chk("k9_rel_t34", {3'b000, is_pressed}, 4'd0);
        chk("k9_rel_data", kdata, 4'h9);
        chk("k9_rel_col", col, 4'b1011);

        // Glitch on row 1 / col 3
        keys[7] = 1'b1;
        tick(1);                                            // 35
        chk("gl_col_t35", col, 4'b0111);
        tick(2);                                            // 37
        chk("gl_pressed_t37", {3'b000, is_pressed}, 4'd0);
        keys = 16'h0000;
        tick(1);                                            // 38 discarded
        chk("gl_pressed_t38", {3'b000, is_pressed}, 4'd0);
        chk("gl_data", kdata, 4'h9);
        chk("gl_col", col, 4'b1110);

        // Row 3 / col 0 with a release bounce
        keys[12] = 1'b1;
        tick(3);                                            // 41
        chk("kc_pressed_t41", {3'b000, is_pressed}, 4'd0);
        tick(1);                                            // 42 accept
        chk("kc_pressed_t42", {3'b000, is_pressed}, 4'd1);
        chk("kc_data", kdata, 4'hC);
        tick(2);                                            // 44
        keys = 16'h0000;
        tick(1);                                            // 45 release seen
        chk("kc_t45", {3'b000, is_pressed}, 4'd1);
        keys[12] = 1'b1;
        tick(1);                                            // 46 bounce low
        chk("kc_bounce", {3'b000, is_pressed}, 4'd1);
        keys = 16'h0000;
        tick(3);                                            // 49
        chk("kc_t49", {3'b000, is_pressed}, 4'd1);
        tick(1);                                            // 50 release accepted
        chk("kc_t50", {3'b000, is_pressed}, 4'd0);
        chk("kc_retained", kdata, 4'hC);
        chk("kc_col", col, 4'b1101);

        // Rows 0 and 2 in col 2: lowest row wins
        keys[2]  = 1'b1;
        keys[10] = 1'b1;
        tick(1);                                            // 51
        chk("mk_col_t51", col, 4'b1011);
        tick(3);                                            // 54
        chk("mk_pressed_t54", {3'b000, is_pressed}, 4'd0);
        tick(1);                                            // 55 accept
        chk("mk_pressed_t55", {3'b000, is_pressed}, 4'd1);
        chk("mk_data", kdata, 4'h2);
        chk("mk_col", col, 4'b1011);

        // Asynchronous reset while in HOLD (no clock edge before the check)
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("rh_pressed", {3'b000, is_pressed}, 4'd0);
        chk("rh_data", kdata, 4'h0);
        chk("rh_col", col, 4'b1110);
        @(negedge clk) sys_rst_n = 1'b1;

        // Keys still closed: re-detect, then reset in DEBOUNCE
        tick(1);
        chk("rd_col_t1", col, 4'b1101);
        tick(2);                                            // detect in col 2
        chk("rd_col_t3", col, 4'b1011);
        tick(1);                                            // debounce in progress
        chk("rd_pressed_t4", {3'b000, is_pressed}, 4'd0);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("rd_pressed", {3'b000, is_pressed}, 4'd0);
        chk("rd_data", kdata, 4'h0);
        chk("rd_col", col, 4'b1110);
        keys = 16'h0000;
        @(negedge clk) sys_rst_n = 1'b1;
        tick(1);
        chk("post_rst_col", col, 4'b1101);
        chk("post_rst_pressed", {3'b000, is_pressed}, 4'd0);

`ifdef KEYPAD_PRESS_PULSE_EN
        chk("kv_cycles", 4'(kv_high), 4'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
